antitheft_timer_sched: RTL and testbench

Shared-timebase timer scheduler for the anti-theft controller. One 50 MHz-to-1 Hz prescaler serves NUM_CH countdown channels, e.g. entry delay, exit delay, siren timeout and LED blink. Requesters load a seconds value through a round-robin arbiter that grants at most one load per cycle. Each channel reports busy and pulses expired when its countdown reaches zero.

---
 rtl/antitheft_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/antitheft_timer_sched.sv | 120 ++++++++++++
 tb/tb_antitheft_timer_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/antitheft_pkg.sv
// Shared constants and types for the anti-theft timer scheduler.
package antitheft_pkg;

  // Channel assignment used by the controller
  localparam int unsigned CH_ENTRY = 0;
  localparam int unsigned CH_EXIT  = 1;
  localparam int unsigned CH_SIREN = 2;
  localparam int unsigned CH_BLINK = 3;

  localparam int unsigned DEFAULT_CLK_HZ  = 50000000;
  localparam int unsigned DEFAULT_SEC_W   = 8;
  // Prescaler period used when SIM_FAST_EN is defined
  localparam int unsigned SIM_FAST_PERIOD = 50;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_EXPIRE
  } ch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot selection of the first eligible index at or
// after the pointer; the pointer moves past each winner.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] elig_i,
  output logic [NUM_CH-1:0] pick_o
);

  localparam int unsigned PTR_W = $clog2(NUM_CH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan from the pointer with wrap; modulo done by one conditional subtract
  always_comb begin
    pick_o = '0;
    ptr_d  = ptr_q;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_CH)) sum = sum - (PTR_W+1)'(NUM_CH);
      idx = sum[PTR_W-1:0];
      if (!found && elig_i[idx]) begin
        found       = 1'b1;
        pick_o[idx] = 1'b1;
        ptr_d       = (32'(idx) == NUM_CH - 1) ? '0 : idx + 1'b1;
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/antitheft_timer_sched.sv
// Shared 1 Hz timebase with NUM_CH countdown channels loaded through a
// round-robin arbiter. Define SIM_FAST_EN to force a 50-cycle prescaler.
module antitheft_timer_sched
  import antitheft_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEC_W  = DEFAULT_SEC_W
) (
  input  logic                    clk_fiftymhz,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*SEC_W-1:0] req_secs,
  input  logic [NUM_CH-1:0]       cancel,
  output logic [NUM_CH-1:0]       gnt,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expired,
  output logic                    tick_1hz
);

`ifdef SIM_FAST_EN
  localparam int unsigned PERIOD = SIM_FAST_PERIOD;
`else
  localparam int unsigned PERIOD = CLK_HZ;
`endif
  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [NUM_CH-1:0] pick;
  logic [NUM_CH-1:0] gnt_q;
  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [SEC_W-1:0]  rem_q   [NUM_CH];
  logic [SEC_W-1:0]  rem_d   [NUM_CH];

  // Free-running prescaler; tick registered one cycle after the terminal count
  always_comb begin
    tick_d = (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_fiftymhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // Cancelled requests are masked out before arbitration
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk_i  (clk_fiftymhz),
    .rst_ni (rst_n),
    .elig_i (req & ~cancel),
    .pick_o (pick)
  );

  // Channel next state: cancel over grant over tick
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      if (cancel[i]) begin
        state_d[i] = CH_IDLE;
        rem_d[i]   = '0;
      end else if (pick[i]) begin
        rem_d[i]   = req_secs[i*SEC_W +: SEC_W];
        state_d[i] = (req_secs[i*SEC_W +: SEC_W] == '0) ? CH_EXPIRE : CH_RUN;
      end else begin
        case (state_q[i])
          CH_RUN: begin
            if (tick_q) begin
              if (rem_q[i] == SEC_W'(1)) begin
                rem_d[i]   = '0;
                state_d[i] = CH_EXPIRE;
              end else begin
                rem_d[i] = rem_q[i] - 1'b1;
              end
            end
          end
          CH_EXPIRE: state_d[i] = CH_IDLE;
          CH_IDLE:   state_d[i] = CH_IDLE;
          default:   state_d[i] = CH_IDLE;
        endcase
      end
    end
  end

  // Channel state, remaining seconds and registered grant
  always_ff @(posedge clk_fiftymhz or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CH_IDLE;
        rem_q[i]   <= '0;
      end
    end else begin
      gnt_q <= pick;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  // Status outputs decoded from registered channel state
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      busy[i]    = (state_q[i] == CH_RUN);
      expired[i] = (state_q[i] == CH_EXPIRE);
    end
  end

  assign gnt      = gnt_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_antitheft_timer_sched.sv
// Scoreboard bench for antitheft_timer_sched with a seconds-level reference model.
module tb_antitheft_timer_sched;

  localparam int NUM_CH = 4;
  localparam int SEC_W  = 8;
  localparam int P      = 50;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [NUM_CH-1:0]       req = '0;
  logic [NUM_CH*SEC_W-1:0] req_secs = '0;
  logic [NUM_CH-1:0]       cancel = '0;
  logic [NUM_CH-1:0]       gnt, busy, expired;
  logic                    tick_1hz;

  always #5 clk = ~clk;

  antitheft_timer_sched #(.CLK_HZ(P), .NUM_CH(NUM_CH), .SEC_W(SEC_W)) dut (
    .clk_fiftymhz (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_secs     (req_secs),
    .cancel       (cancel),
    .gnt          (gnt),
    .busy         (busy),
    .expired      (expired),
    .tick_1hz     (tick_1hz)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                tag;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] exp;
    logic              tick;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: seconds left per channel (0 = idle), pointer, edges since release
  int                rem[NUM_CH];
  int                ptr;
  int                since_rel;
  logic [NUM_CH-1:0] m_gnt, m_busy, m_exp;
  logic              m_tick;

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) rem[c] = 0;
    ptr = 0; since_rel = 0;
    m_gnt = '0; m_busy = '0; m_exp = '0; m_tick = 1'b0;
  endfunction

  function automatic void model_step();
    int k = -1;
    logic [NUM_CH-1:0] ng = '0;
    logic [NUM_CH-1:0] ne = '0;
    logic [NUM_CH-1:0] nb = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      int idx = (ptr + j) % NUM_CH;
      if (k < 0 && req[idx] && !cancel[idx]) k = idx;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (cancel[c]) rem[c] = 0;
      else if (c == k) begin
        rem[c] = int'(req_secs[c*SEC_W +: SEC_W]);
        ng[c] = 1'b1;
        if (rem[c] == 0) ne[c] = 1'b1;
      end else if (m_tick && rem[c] > 0) begin
        rem[c] = rem[c] - 1;
        if (rem[c] == 0) ne[c] = 1'b1;
      end
      nb[c] = (rem[c] > 0);
    end
    if (k >= 0) ptr = (k + 1) % NUM_CH;
    since_rel = since_rel + 1;
    m_tick = (since_rel % P == 0);
    m_gnt = ng; m_exp = ne; m_busy = nb;
    sb.push_back(exp_t'{cyc + 1, m_gnt, m_busy, m_exp, m_tick});
  endfunction

  // Monitor: checks reset values, otherwise pops the expectation for this edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        n_checks++;
        if ({gnt, busy, expired, tick_1hz} != '0) begin
          n_fail++;
          $display("FAIL reset_outs cyc %0d: gnt=%b busy=%b expired=%b tick=%b, required all 0",
                   cyc, gnt, busy, expired, tick_1hz);
        end
      end else if (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (e.tag != cyc) begin
          n_fail++;
          $display("FAIL sb_order: expectation tag %0d, required %0d", e.tag, cyc);
        end else if (gnt !== e.gnt || busy !== e.busy || expired !== e.exp || tick_1hz !== e.tick) begin
          n_fail++;
          $display("FAIL outputs cyc %0d: gnt=%b busy=%b expired=%b tick=%b, required gnt=%b busy=%b expired=%b tick=%b",
                   cyc, gnt, busy, expired, tick_1hz, e.gnt, e.busy, e.exp, e.tick);
        end
      end
    end
  end

  // Requesters drop req in the cycle their grant is seen
  task automatic advance();
    @(posedge clk); #1;
    req = req & ~m_gnt;
  endtask

  task automatic commit();
    model_step();
  endtask

  task automatic run(input int n);
    repeat (n) begin advance(); commit(); end
  endtask

  task automatic load(input int ch, input int s);
    req[ch] = 1'b1;
    req_secs[ch*SEC_W +: SEC_W] = SEC_W'(s);
  endtask

  task automatic do_reset(input int n);
    advance();
    rst_n = 1'b0; req = '0; cancel = '0;
    sb.delete();
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    commit();
  endtask

  initial begin
    bit found;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    commit();
    run(200);                                   // prescaler ticks at 50,100,150,200

    advance(); load(0, 3); commit(); run(200);  // single 3 s timer
    advance(); load(0, 0); commit(); run(5);    // zero load: expired with gnt

    advance(); for (int c = 0; c < NUM_CH; c++) load(c, 10 + c); commit(); run(6);
    advance(); load(0, 1); load(2, 1); commit(); run(4);
    advance(); load(0, 2); commit(); run(3);    // pointer now 1
    advance(); load(0, 3); load(2, 3); commit(); run(250);

    advance(); load(1, 5); commit(); run(80);   // cancel mid-run
    advance(); cancel[1] = 1'b1; commit();
    advance(); cancel = '0; commit(); run(5);

    advance(); load(2, 4); cancel[2] = 1'b1; commit();  // cancel masks grant
    advance(); cancel = '0; req[2] = 1'b0; commit(); run(3);

    found = 1'b0;                               // grant in a tick cycle
    for (int i = 0; i < 60 && !found; i++) begin
      advance();
      if (m_tick) begin load(3, 2); found = 1'b1; end
      commit();
    end
    run(160);

    advance(); load(0, 2); load(1, 2); commit(); run(150);  // simultaneous expiry

    advance(); load(2, 2); commit();            // reload at remaining 1
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      advance();
      if (rem[2] == 1) begin load(2, 4); found = 1'b1; end
      commit();
    end
    run(260);

    advance(); load(0, 9); load(1, 9); load(2, 9); commit(); run(60);
    do_reset(3);                                // reset mid-run
    run(300);

    repeat (3000) begin                         // random traffic
      advance();
      for (int c = 0; c < NUM_CH; c++) begin
        if (!req[c] && $urandom_range(0, 19) == 0) load(c, int'($urandom_range(0, 6)));
        cancel[c] = ($urandom_range(0, 39) == 0);
      end
      commit();
    end

    advance(); req = '0; cancel = '0; commit();
    @(posedge clk); #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
